// File: rtl/rpn_pkg.sv
// Shared types for the RPN evaluator: opcodes, error codes and FSM states.
// Macro RPN_MUL_EN enables opcode 6 (MUL).
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_EMIT = 3'd5,
    OP_MUL  = 3'd6
  } opcode_e;

  localparam logic [1:0] ERR_OVERFLOW  = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_B,
    POP_A,
    CALC,
    PUSH_RES,
    EMIT_CAP,
    ERR
  } state_e;

  // Low three opcode bits recognised by this build.
  function automatic logic op_legal(input logic [2:0] code);
`ifdef RPN_MUL_EN
    return code <= 3'd6;
`else
    return code <= 3'd5;
`endif
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN evaluator; result is A op B mod 2^DATA_W.
// MUL path present only when RPN_MUL_EN is defined.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  opcode_e           op_i,
  output logic [DATA_W-1:0] y_o
);

  // Select the operation; carries and borrows fall off the top.
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
`ifdef RPN_MUL_EN
      OP_MUL:  y_o = a_i * b_i;
`endif
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator; sole master of a LIFO stack whose data_out is
// valid the cycle after a pop. Macro RPN_MUL_EN enables opcode 6 (MUL).
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic              tok_is_op,
  input  logic [DATA_W-1:0] tok_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic              stk_full,
  input  logic              stk_empty
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [DATA_W-1:0] data_q, b_q, alu_q, res_data_q, alu_y;
  opcode_e           op_q;
  logic              res_valid_q;
  logic              legal;

  assign legal = ((tok_data >> 3) == '0) && op_legal(tok_data[2:0]);

  rpn_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i  (stk_dout),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  // Next-state, occupancy and error-code decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (cnt_q == CNT_W'(STACK_DEPTH) || stk_full) begin
              state_d = ERR; err_code_d = ERR_OVERFLOW;
            end else begin
              state_d = PUSH;
            end
          end else if (!legal) begin
            state_d = ERR; err_code_d = ERR_ILLEGAL;
          end else if (tok_data[2:0] == OP_EMIT) begin
            if (cnt_q == '0) begin
              state_d = ERR; err_code_d = ERR_UNDERFLOW;
            end else begin
              state_d = POP_B;
            end
          end else if (cnt_q < CNT_W'(2)) begin
            state_d = ERR; err_code_d = ERR_UNDERFLOW;
          end else begin
            state_d = POP_B;
          end
        end
      end
      PUSH: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      POP_B: begin
        if (stk_empty) begin
          state_d = ERR; err_code_d = ERR_UNDERFLOW; cnt_d = '0;
        end else begin
          state_d = (op_q == OP_EMIT) ? EMIT_CAP : POP_A;
        end
      end
      POP_A: begin
        if (stk_empty) begin
          state_d = ERR; err_code_d = ERR_UNDERFLOW; cnt_d = '0;
        end else begin
          state_d = CALC;
        end
      end
      CALC:     state_d = PUSH_RES;
      PUSH_RES: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = IDLE;
      end
      EMIT_CAP: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = IDLE;
      end
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, occupancy and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_code_q  <= '0;
      data_q      <= '0;
      op_q        <= OP_ADD;
      b_q         <= '0;
      alu_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_code_q  <= err_code_d;
      res_valid_q <= (state_q == EMIT_CAP);
      if (state_q == IDLE && tok_valid) begin
        data_q <= tok_data;
        op_q   <= opcode_e'(tok_data[2:0]);
      end
      if (state_q == POP_A)    b_q        <= stk_dout;
      if (state_q == CALC)     alu_q      <= alu_y;
      if (state_q == EMIT_CAP) res_data_q <= stk_dout;
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge.
  always_comb begin
    tok_ready = !rst && (state_q == IDLE);
    stk_push  = !rst && (state_q == PUSH || state_q == PUSH_RES);
    stk_pop   = !rst && (state_q == POP_B || state_q == POP_A) && !stk_empty;
    stk_din   = '0;
    if (!rst && state_q == PUSH)     stk_din = data_q;
    if (!rst && state_q == PUSH_RES) stk_din = alu_q;
    err_valid = !rst && (state_q == ERR);
    err_code  = rst ? 2'd0 : err_code_q;
    res_valid = !rst && res_valid_q;
    res_data  = rst ? '0 : res_data_q;
  end

endmodule

// File: tb/tb_rpn_eval.sv
// Self-checking bench for rpn_eval with a behavioural LIFO and a queue-based
// RPN reference model. Honours RPN_MUL_EN.
module tb_rpn_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       tok_valid, tok_ready, tok_is_op;
  logic [3:0] tok_data;
  logic       res_valid, err_valid, stk_push, stk_pop, stk_full, stk_empty;
  logic [3:0] res_data, stk_din, stk_dout;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int model_q[$];

  always #5 clk = ~clk;

  rpn_eval #(.DATA_W(4), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data), .res_valid(res_valid),
    .res_data(res_data), .err_valid(err_valid), .err_code(err_code),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  // Behavioural 8-deep stack; data_out registered on pop.
  logic [3:0] mem [8];
  int sp;
  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      stk_dout <= 4'd0;
    end else if (stk_push && sp < 8) begin
      mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end
  assign stk_full  = (sp == 8);
  assign stk_empty = (sp == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {tok_ready, res_valid, res_data, err_valid, err_code,
              stk_push, stk_pop, stk_din}, 32'd0);
  endtask

  // Apply one token and compare the following cycles against the model.
  task automatic run_token(input bit is_op, input int val);
    logic [7:0] e_push = 0, e_pop = 0, e_res = 0, e_err = 0;
    logic [7:0] o_push = 0, o_pop = 0, o_res = 0, o_err = 0;
    int e_rdata = 0, e_code = 0, o_rdata = 0, o_code = 0, a, b, r, w;
    bit overlap = 0;
    if (!is_op) begin
      if (model_q.size() == 8) begin e_err = 8'b10; e_code = 0; end
      else begin model_q.push_back(val); e_push = 8'b10; end
    end else if (val == 5) begin
      if (model_q.size() == 0) begin e_err = 8'b10; e_code = 1; end
      else begin e_rdata = model_q.pop_back(); e_pop = 8'b10; e_res = 8'b1000; end
`ifdef RPN_MUL_EN
    end else if (val <= 6) begin
`else
    end else if (val <= 4) begin
`endif
      if (model_q.size() < 2) begin e_err = 8'b10; e_code = 1; end
      else begin
        b = model_q.pop_back();
        a = model_q.pop_back();
        case (val)
          0: r = a + b;
          1: r = a - b;
          2: r = a & b;
          3: r = a | b;
          4: r = a ^ b;
          default: r = a * b;
        endcase
        model_q.push_back(r & 15);
        e_pop = 8'b110; e_push = 8'b10000;
      end
    end else begin
      e_err = 8'b10; e_code = 2;
    end

    w = 0;
    while (!tok_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_wait", tok_ready, 1);
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = 4'(val);
    @(posedge clk);
    #1;
    tok_valid = 1'b0; tok_is_op = 1'($urandom); tok_data = 4'($urandom);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (stk_push) o_push[k] = 1'b1;
      if (stk_pop)  o_pop[k]  = 1'b1;
      if (stk_push && stk_pop) overlap = 1;
      if (res_valid) begin o_res[k] = 1'b1; o_rdata = res_data; end
      if (err_valid) begin o_err[k] = 1'b1; o_code = err_code; end
    end
    chk("push_cycles", o_push, e_push);
    chk("pop_cycles",  o_pop,  e_pop);
    chk("res_cycles",  o_res,  e_res);
    chk("err_cycles",  o_err,  e_err);
    chk("push_pop_overlap", overlap, 0);
    if (e_res != 0) chk("res_data", o_rdata, e_rdata);
    if (e_err != 0) chk("err_code", o_code, e_code);
    chk("occupancy", dut.cnt_q, model_q.size());
    chk("stack_depth", sp, model_q.size());
    chk("ready_after", tok_ready, 1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    model_q.delete();
    #1 chk_outputs_zero("outputs_in_reset");
    repeat (cycles) @(negedge clk);
    chk_outputs_zero("outputs_in_reset_late");
    rst = 1'b0;
    #1;
    chk("ready_after_reset", tok_ready, 1);
    chk("cnt_after_reset", dut.cnt_q, 0);
  endtask

  initial begin
    rst = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 4'd0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rst = 1'b0;
    #1 chk("ready_first_cycle", tok_ready, 1);

    // Empty-stack EMIT, ADD wrap, SUB operand order.
    run_token(1, 5);
    run_token(0, 13); run_token(0, 15); run_token(1, 0); run_token(1, 5);
    run_token(0, 2);  run_token(0, 9);  run_token(1, 1); run_token(1, 5);

    // Opcode 6 (MUL or illegal) and other illegal opcodes.
    run_token(0, 3); run_token(0, 9); run_token(1, 6); run_token(1, 5);
    run_token(1, 7); run_token(1, 15);

    // Binary op with a single entry underflows and leaves the stack alone.
    do_reset(2);
    run_token(0, 4); run_token(1, 2); run_token(1, 5);

    // Fill to depth, then overflow.
    do_reset(1);
    for (int i = 0; i < 9; i++) run_token(0, $urandom_range(0, 15));

    // Reset during CALC of an ADD: no push, outputs low, ready on release.
    do_reset(1);
    run_token(0, 1); run_token(0, 2);
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 4'd0;
    @(posedge clk);
    #1 tok_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_calc_no_push", stk_push, 0);
    rst = 1'b1;
    model_q.delete();
    #1 chk_outputs_zero("reset_mid_calc");
    @(negedge clk);
    chk_outputs_zero("reset_mid_calc_hold");
    rst = 1'b0;
    #1 chk("ready_after_mid_reset", tok_ready, 1);
    chk("stack_empty_after_mid_reset", sp, 0);

    // Random token stream.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 0) run_token(0, $urandom_range(0, 15));
      else run_token(1, $urandom_range(0, 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
